ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Multi-cycle control FSM for the basic processor datapath. Sequences fetch/decode/execute/
//  memory/writeback per 9-bit instruction (opcode = Instruction[8:5], from the definitions package),
//  drives PC, register-file, ALU and data-memory controls. Handshakes with the testbench via
//  Start/Ack and with data memory via MemReady. Sits between instruction ROM and datapath.
// PARAMETERS
//  IW        9   instruction width; opcode is bits [IW-1:IW-4]
//  MAX_WAIT  8   max cycles in MEM awaiting MemReady before timeout
//  CW        16  width of CycleCount
// PORTS
//  Clk          in   1    clock, rising edge
//  Reset        in   1    asynchronous active-low reset
//  Start        in   1    level; rising edge (registered compare) in IDLE begins program at PC=0
//  Instruction  in   IW   current instruction from instruction ROM
//  Zero         in   1    ALU zero flag, valid in EXEC
//  MemReady     in   1    data memory has completed the current read/write
//  FetchEn      out  1    load instruction register
//  PCInit       out  1    force PC to 0
//  PCInc        out  1    PC <= PC+1
//  BranchEn     out  1    PC <= branch target
//  ALUOp        out  4    ALU operation (opcode passthrough, latched in DECODE)
//  RegWrite     out  1    register file write enable
//  MemRead      out  1    data memory read request
//  MemWrite     out  1    data memory write request
//  Ack          out  1    program finished (one-cycle pulse)
//  Error        out  1    sticky: illegal opcode or memory timeout
//  CycleCount   out  CW   cycles since Start accepted, saturating
// BEHAVIOUR
//  Reset (Reset=0, async): state=IDLE; all outputs 0; CycleCount=0; Error=0; latched opcode=0.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE. All outputs registered-state Moore decode.
//  IDLE: PCInit=1. Start rising edge -> FETCH; clears Error and CycleCount. Start while not IDLE ignored.
//  FETCH (1 cyc): FetchEn=1 -> DECODE.
//  DECODE (1 cyc): latch opcode into ALUOp -> EXEC; ALUOp held until next DECODE.
//  EXEC (1 cyc): opcode 4'b1111 (HALT) -> DONE. 4'b1110 -> Error=1, treated as NOP -> WB.
//    LDR/STR -> MEM. BNZ: taken_q <= ~Zero -> WB. All others -> WB.
//  MEM: MemRead=1 (LDR) or MemWrite=1 (STR) held until MemReady=1 sampled -> WB.
//    Wait counter clears on entry; if MemReady not seen within MAX_WAIT cycles -> Error=1, DONE.
//    MemReady in the same cycle as counter hitting MAX_WAIT counts as success.
//  WB (1 cyc): RegWrite=1 for LSH,RSH,AND,OR,LDI,LDR,GEQ,EQ,NEG,ADD,ADDI,NEQ; 0 for STR,BNZ,1110.
//    BNZ with taken_q: BranchEn=1, PCInc=0; else PCInc=1. -> FETCH.
//  DONE (1 cyc): Ack=1 -> IDLE. PCInc/RegWrite not asserted for HALT.
//  Latency: ALU op/LDI = 4 cycles; LDR/STR = 5 + memory wait; BNZ = 4.
//  BranchEn and PCInc never both 1; MemRead and MemWrite never both 1.
//  CycleCount increments every cycle state != IDLE; saturates at all-ones; holds in IDLE.
//  Reset mid-operation: immediate return to IDLE, pending memory request dropped (MemRead/Write=0).
// TESTING
//  T1 reset: Reset=0 mid-EXEC -> all outputs 0, state IDLE, CycleCount=0, same cycle.
//  T2 ADD (opcode 1011) then HALT: Start -> FetchEn@1, ALUOp=1011 from 2, RegWrite+PCInc@3,
//     then HALT fetch; Ack pulse at cycle 7, CycleCount=8 at return to IDLE.
//  T3 LDR with MemReady after 3 cycles: MemRead high exactly 3 cycles (MemReady on 3rd), then
//     RegWrite=1, PCInc=1 in WB.
//  T4 BNZ: Zero=0 -> WB BranchEn=1, PCInc=0; Zero=1 -> PCInc=1, BranchEn=0; RegWrite=0 both.
//  T5 STR, MemReady never asserted, MAX_WAIT=8: MemWrite high 8 cycles -> Error=1, Ack pulse,
//     IDLE; next Start clears Error.
//  T6 opcode 1110: Error=1, no RegWrite, PCInc=1, execution continues; Start pulsed while busy ignored.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM for the basic processor datapath: walks each instruction through
// FETCH/DECODE/EXEC/(MEM)/WB and drives PC, register-file, ALU and data-memory controls.
module ctrl_sequencer #(
    parameter int IW       = 9,
    parameter int MAX_WAIT = 8,
    parameter int CW       = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] Instruction,
    input  logic          Zero,
    input  logic          MemReady,
    output logic          FetchEn,
    output logic          PCInit,
    output logic          PCInc,
    output logic          BranchEn,
    output logic [3:0]    ALUOp,
    output logic          RegWrite,
    output logic          MemRead,
    output logic          MemWrite,
    output logic          Ack,
    output logic          Error,
    output logic [CW-1:0] CycleCount,
    output logic [2:0]    dbg_state
);

    localparam logic [3:0] OP_LSH  = 4'b0000;
    localparam logic [3:0] OP_RSH  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_LDI  = 4'b0100;
    localparam logic [3:0] OP_LDR  = 4'b0101;
    localparam logic [3:0] OP_STR  = 4'b0110;
    localparam logic [3:0] OP_BNZ  = 4'b0111;
    localparam logic [3:0] OP_GEQ  = 4'b1000;
    localparam logic [3:0] OP_EQ   = 4'b1001;
    localparam logic [3:0] OP_NEG  = 4'b1010;
    localparam logic [3:0] OP_ADD  = 4'b1011;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_NEQ  = 4'b1101;
    localparam logic [3:0] OP_ILL  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          start_q;
    logic          taken_q;
    logic          taken_nxt;
    logic [WW-1:0] wait_cnt;
    logic          accept;
    logic          timeout;
    logic          wb_write;
    logic          wb_branch;
    logic [3:0]    opcode;
    logic          unused_bits;

    assign opcode      = Instruction[IW-1:IW-4];
    assign unused_bits = ^Instruction[IW-5:0];
    assign dbg_state   = state;

    // Handshakes: Start is a level whose rising edge (against start_q) is only honoured in
    // IDLE; MemReady completes the request in the same cycle it is sampled high in MEM.
    always_comb begin
        state_nxt = state;
        taken_nxt = taken_q;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start && !start_q) begin
                    accept    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                case (ALUOp)
                    OP_HALT:        state_nxt = S_DONE;
                    OP_LDR, OP_STR: state_nxt = S_MEM;
                    OP_BNZ: begin
                        taken_nxt = ~Zero;
                        state_nxt = S_WB;
                    end
                    default:        state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (MemReady) begin
                    state_nxt = S_WB;
                end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_WB:    state_nxt = S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wb_write  = !(ALUOp inside {OP_STR, OP_BNZ, OP_ILL, OP_HALT});
    assign wb_branch = (ALUOp == OP_BNZ) && taken_nxt;

    // Outputs are registered from the next state so each one is a clean Moore decode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            taken_q    <= 1'b0;
            wait_cnt   <= '0;
            ALUOp      <= 4'b0000;
            CycleCount <= '0;
            Error      <= 1'b0;
            FetchEn    <= 1'b0;
            PCInit     <= 1'b0;
            PCInc      <= 1'b0;
            BranchEn   <= 1'b0;
            RegWrite   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Ack        <= 1'b0;
        end else begin
            state    <= state_nxt;
            start_q  <= Start;
            taken_q  <= taken_nxt;
            wait_cnt <= (state == S_MEM) ? wait_cnt + WW'(1) : '0;
            if (state == S_DECODE) begin
                ALUOp <= opcode;
            end
            if (accept) begin
                CycleCount <= '0;
            end else if (state != S_IDLE && CycleCount != '1) begin
                CycleCount <= CycleCount + CW'(1);
            end
            if (accept) begin
                Error <= 1'b0;
            end else if ((state == S_EXEC && ALUOp == OP_ILL) || timeout) begin
                Error <= 1'b1;
            end
            PCInit   <= (state_nxt == S_IDLE);
            FetchEn  <= (state_nxt == S_FETCH);
            MemRead  <= (state_nxt == S_MEM) && (ALUOp == OP_LDR);
            MemWrite <= (state_nxt == S_MEM) && (ALUOp == OP_STR);
            RegWrite <= (state_nxt == S_WB) && wb_write;
            BranchEn <= (state_nxt == S_WB) && wb_branch;
            PCInc    <= (state_nxt == S_WB) && !wb_branch;
            Ack      <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: a small ROM/PC model feeds instructions, a trace generator
// queues the expected per-cycle output vector, and every cycle is compared against it.
module tb_ctrl_sequencer;

    localparam int MAX_WAIT = 8;

    localparam logic [3:0] OP_LSH  = 4'b0000;
    localparam logic [3:0] OP_LDR  = 4'b0101;
    localparam logic [3:0] OP_STR  = 4'b0110;
    localparam logic [3:0] OP_BNZ  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1011;
    localparam logic [3:0] OP_ILL  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_DONE = 3'd6;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [8:0]  Instruction;
    logic        Zero;
    logic        MemReady;
    logic        FetchEn, PCInit, PCInc, BranchEn, RegWrite, MemRead, MemWrite, Ack, Error;
    logic [3:0]  ALUOp;
    logic [15:0] CycleCount;
    logic [2:0]  dbg_state;

    logic [8:0]  rom [32];
    logic [4:0]  pc;
    int          mem_delay;
    int          mem_cnt;
    logic [3:0]  m_alu;
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    ctrl_sequencer #(.IW(9), .MAX_WAIT(MAX_WAIT), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .Zero(Zero),
        .MemReady(MemReady), .FetchEn(FetchEn), .PCInit(PCInit), .PCInc(PCInc),
        .BranchEn(BranchEn), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Ack(Ack), .Error(Error), .CycleCount(CycleCount),
        .dbg_state(dbg_state)
    );

    // Clock and reset-driven datapath stand-ins
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign Instruction = rom[pc];

    always @(posedge Clk or negedge Reset) begin
        if (!Reset)        pc <= 5'd0;
        else if (PCInit)   pc <= 5'd0;
        else if (BranchEn) pc <= Instruction[4:0];
        else if (PCInc)    pc <= pc + 5'd1;
    end

    // Memory responder: raises MemReady on the mem_delay-th request cycle (never if 0)
    always @(negedge Clk) begin
        if (Reset && (MemRead || MemWrite)) begin
            mem_cnt  = mem_cnt + 1;
            MemReady = (mem_delay != 0) && (mem_cnt == mem_delay);
        end else begin
            mem_cnt  = 0;
            MemReady = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] actual_vec();
        return {dbg_state, FetchEn, PCInit, PCInc, BranchEn, ALUOp,
                RegWrite, MemRead, MemWrite, Ack, Error, CycleCount};
    endfunction

    // flags = {FetchEn, PCInit, PCInc, BranchEn}; f2 = {RegWrite, MemRead, MemWrite, Ack, Error}
    function automatic logic [31:0] mk(input logic [2:0] st, input logic [3:0] flags,
                                       input logic [3:0] alu, input logic [4:0] f2,
                                       input int cyc);
        logic [15:0] c;
        c = cyc[15:0];
        return {st, flags, alu, f2, c};
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        return !(op == OP_STR || op == OP_BNZ || op == OP_ILL || op == OP_HALT);
    endfunction

    // Expected trace of one program run from the FETCH cycle to the IDLE cycle after DONE
    task automatic gen_trace();
        logic [4:0] p;
        logic [3:0] op;
        logic       err;
        logic       br;
        int         cyc;
        int         n;
        p   = 5'd0;
        cyc = 0;
        err = 1'b0;
        for (int g = 0; g < 32; g++) begin
            op = rom[p][8:5];
            exp_q.push_back(mk(S_FETCH, 4'b1000, m_alu, {4'b0000, err}, cyc)); cyc++;
            exp_q.push_back(mk(S_DECODE, 4'b0000, m_alu, {4'b0000, err}, cyc)); cyc++;
            m_alu = op;
            exp_q.push_back(mk(S_EXEC, 4'b0000, m_alu, {4'b0000, err}, cyc)); cyc++;
            if (op == OP_HALT) begin
                exp_q.push_back(mk(S_DONE, 4'b0000, m_alu, {4'b0001, err}, cyc)); cyc++;
                exp_q.push_back(mk(S_IDLE, 4'b0100, m_alu, {4'b0000, err}, cyc));
                return;
            end
            if (op == OP_ILL) err = 1'b1;
            if (op == OP_LDR || op == OP_STR) begin
                n = (mem_delay == 0) ? MAX_WAIT : mem_delay;
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back(mk(S_MEM, 4'b0000, m_alu,
                                       {1'b0, op == OP_LDR, op == OP_STR, 1'b0, err}, cyc));
                    cyc++;
                end
                if (mem_delay == 0) begin
                    err = 1'b1;
                    exp_q.push_back(mk(S_DONE, 4'b0000, m_alu, {4'b0001, err}, cyc)); cyc++;
                    exp_q.push_back(mk(S_IDLE, 4'b0100, m_alu, {4'b0000, err}, cyc));
                    return;
                end
            end
            br = (op == OP_BNZ) && !Zero;
            exp_q.push_back(mk(S_WB, {2'b00, !br, br}, m_alu, {writes_reg(op), 3'b000, err}, cyc));
            cyc++;
            p = br ? rom[p][4:0] : p + 5'd1;
        end
    endtask

    // Driver: pulse Start in IDLE, then compare one queued vector per cycle
    task automatic run_program(input string tag, input int pulse_at);
        int n;
        gen_trace();
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        n = 0;
        while (exp_q.size() > 0) begin
            if (n == pulse_at)     Start = 1'b1;
            if (n == pulse_at + 2) Start = 1'b0;
            check(tag, actual_vec(), exp_q.pop_front());
            n++;
            if (exp_q.size() > 0) @(negedge Clk);
        end
        Start = 1'b0;
    endtask

    task automatic load_rom(input logic [8:0] i0, input logic [8:0] i1, input logic [8:0] i2);
        for (int i = 0; i < 32; i++) rom[i] = {OP_HALT, 5'd0};
        rom[0] = i0;
        rom[1] = i1;
        rom[2] = i2;
    endtask

    task automatic reset_mid(input string tag, input logic [2:0] stop_state);
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        for (int k = 0; k < 20 && dbg_state != stop_state; k++) @(negedge Clk);
        check({tag, "_reach"}, {29'd0, dbg_state}, {29'd0, stop_state});
        #2 Reset = 1'b0;
        #1 check({tag, "_async"}, actual_vec(), 32'h0);
        @(negedge Clk) Reset = 1'b1;
        m_alu = 4'b0000;
        @(negedge Clk) check({tag, "_idle"}, actual_vec(), mk(S_IDLE, 4'b0100, 4'b0000, 5'b0, 0));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        Reset     = 1'b1;
        Start     = 1'b0;
        Zero      = 1'b0;
        MemReady  = 1'b0;
        mem_delay = 0;
        mem_cnt   = 0;
        m_alu     = 4'b0000;
        load_rom({OP_HALT, 5'd0}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});

        #3 Reset = 1'b0;
        #1 check("por_reset", actual_vec(), 32'h0);
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) check("por_idle", actual_vec(), mk(S_IDLE, 4'b0100, 4'b0000, 5'b0, 0));

        load_rom({OP_ADD, 5'd0}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});
        run_program("add_halt", -1);

        load_rom({OP_LDR, 5'd0}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});
        mem_delay = 3;
        run_program("ldr_wait3", -1);

        load_rom({OP_BNZ, 5'd2}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});
        Zero = 1'b0;
        run_program("bnz_taken", -1);
        Zero = 1'b1;
        run_program("bnz_not_taken", -1);
        Zero = 1'b0;

        load_rom({OP_STR, 5'd0}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});
        mem_delay = 0;
        run_program("str_timeout", -1);

        load_rom({OP_ILL, 5'd0}, {OP_LSH, 5'd0}, {OP_HALT, 5'd0});
        run_program("illegal_busy_start", 3);

        load_rom({OP_LDR, 5'd0}, {OP_STR, 5'd0}, {OP_HALT, 5'd0});
        mem_delay = MAX_WAIT;
        run_program("mem_ready_last", -1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) rom[i] = {OP_HALT, 5'd0};
            for (int i = 0; i < 6; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 14));
                rom[i] = {op, (op == OP_BNZ) ? 5'(i + 1) : 5'($urandom_range(0, 31))};
            end
            mem_delay = $urandom_range(1, MAX_WAIT);
            Zero      = 1'($urandom_range(0, 1));
            run_program("random_prog", -1);
        end

        load_rom({OP_ADD, 5'd0}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});
        reset_mid("reset_exec", S_EXEC);
        load_rom({OP_LDR, 5'd0}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});
        mem_delay = 0;
        reset_mid("reset_mem", S_MEM);

        load_rom({OP_ADD, 5'd0}, {OP_HALT, 5'd0}, {OP_HALT, 5'd0});
        run_program("after_reset", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
